pipeline_elastic: RTL and testbench

- Parametrised successor to the basic valid/ready stage chain.
- NUMS-deep elastic pipeline: bubbles collapse, an optional input skid buffer registers in_ready, a synchronous flush drops all in-flight data, and an occupancy counter is exposed.
- Optional per-stage increment transform gives a deterministic, checkable datapath.
- Sits between any two valid/ready producers/consumers in the design as a latency/timing-closure element.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/pipeline_skid.sv | 48 ++++
 rtl/pipeline_elastic.sv | 104 ++++++++++
 tb/tb_pipeline_elastic.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and the per-stage datapath transform for the elastic pipeline.
package pipeline_pkg;

   localparam int MODE_PASS = 0;
   localparam int MODE_INC  = 1;
   localparam int MAX_BITS  = 64;

   // Callers zero-extend into MAX_BITS and truncate the result back to BITS,
   // which gives the modulo 2^BITS wrap of the increment mode for free.
   function automatic logic [MAX_BITS-1:0] stage_f(input logic [MAX_BITS-1:0] value,
                                                   input int                  mode);
      return (mode == MODE_INC) ? value + MAX_BITS'(1) : value;
   endfunction

endpackage

// File: rtl/pipeline_skid.sv
// One-entry input skid buffer: in_ready_o comes from the entry register, so
// upstream never sees a combinational path from the downstream ready chain.
module pipeline_skid #(
   parameter int BITS = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic [BITS-1:0] in_value_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   output logic [BITS-1:0] out_value_o,
   output logic            out_valid_o,
   input  logic            out_ready_i
);

   logic            sk_vld_q, sk_vld_d;
   logic [BITS-1:0] sk_val_q, sk_val_d;

   assign in_ready_o  = ~sk_vld_q & ~flush_i;
   assign out_valid_o = sk_vld_q | (in_valid_i & in_ready_o);
   assign out_value_o = sk_vld_q ? sk_val_q : in_value_i;

   always_comb begin
      sk_vld_d = sk_vld_q;
      sk_val_d = sk_val_q;
      if (flush_i) begin
         sk_vld_d = 1'b0;
      end else if (sk_vld_q) begin
         if (out_ready_i) sk_vld_d = 1'b0;
      end else if (in_valid_i && in_ready_o && !out_ready_i) begin
         // Stage 1 is blocked: park the accepted word until the chain moves.
         sk_vld_d = 1'b1;
         sk_val_d = in_value_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sk_vld_q <= 1'b0;
         sk_val_q <= '0;
      end else begin
         sk_vld_q <= sk_vld_d;
         sk_val_q <= sk_val_d;
      end
   end

endmodule

// File: rtl/pipeline_elastic.sv
// NUMS-deep elastic valid/ready pipeline with bubble collapse, optional input
// skid buffer, synchronous flush and an occupancy counter.
module pipeline_elastic
   import pipeline_pkg::*;
#(
   parameter int NUMS = 10,
   parameter int BITS = 8,
   parameter int SKID = 1,
   parameter int MODE = MODE_PASS
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [BITS-1:0]           in_value,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [BITS-1:0]           out_value,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(NUMS+2)-1:0] count
);

   localparam int CW = $clog2(NUMS+2);

   typedef struct packed {
      logic [BITS-1:0] value;
      logic            valid;
      logic            ready;
   } state_t;

   logic [NUMS:1]           vld_q, vld_d;
   logic [NUMS:1][BITS-1:0] val_q, val_d;
   logic [CW-1:0]           count_q, count_d;
   logic [NUMS:0]           rdy;
   state_t [NUMS-1:0]       src;
   logic                    s0_valid;
   logic [BITS-1:0]         s0_value;
   logic                    acc_in, acc_out;

   // A stage can take new data when it is empty or its successor moves.
   always_comb begin
      rdy       = '0;
      rdy[NUMS] = out_ready;
      for (int k = NUMS; k >= 1; k--) rdy[k-1] = ~vld_q[k] | rdy[k];
   end

   if (SKID != 0) begin : g_skid
      pipeline_skid #(.BITS(BITS)) u_skid (
         .clk_i       (clock),
         .rst_ni      (reset_n),
         .flush_i     (flush),
         .in_value_i  (in_value),
         .in_valid_i  (in_valid),
         .in_ready_o  (in_ready),
         .out_value_o (s0_value),
         .out_valid_o (s0_valid),
         .out_ready_i (rdy[0])
      );
   end else begin : g_bypass
      assign in_ready = rdy[0] & ~flush;
      assign s0_valid = in_valid & in_ready;
      assign s0_value = in_value;
   end

   // src[k] is the view of stage k as seen by stage k+1.
   always_comb begin
      src    = '0;
      src[0] = '{value: s0_value, valid: s0_valid, ready: rdy[0]};
      for (int k = 1; k < NUMS; k++) src[k] = '{value: val_q[k], valid: vld_q[k], ready: rdy[k]};
   end

   always_comb begin
      vld_d = vld_q;
      val_d = val_q;
      for (int k = 1; k <= NUMS; k++) begin
         if (src[k-1].ready) begin
            vld_d[k] = src[k-1].valid;
            if (src[k-1].valid) val_d[k] = BITS'(stage_f(MAX_BITS'(src[k-1].value), MODE));
         end
      end
      if (flush) vld_d = '0;
   end

   assign acc_in  = in_valid & in_ready;
   assign acc_out = vld_q[NUMS] & out_ready;
   assign count_d = flush ? '0 : count_q + CW'(acc_in) - CW'(acc_out);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q   <= '0;
         val_q   <= '0;
         count_q <= '0;
      end else begin
         vld_q   <= vld_d;
         val_q   <= val_d;
         count_q <= count_d;
      end
   end

   assign out_valid = vld_q[NUMS];
   assign out_value = val_q[NUMS];
   assign count     = count_q;

endmodule

// File: tb/tb_pipeline_elastic.sv
// Scoreboard bench: a NUMS=10 SKID=1 pass-through pipe plus a SKID=0 increment pipe.
module tb_pipeline_elastic;

   logic       clock = 1'b0;
   logic       reset_n, flush;
   logic [7:0] in_value, out_value;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] count;

   logic       i2_flush, i2_in_valid, i2_in_ready, i2_out_valid, i2_out_ready;
   logic [7:0] i2_in_value, i2_out_value;
   logic [3:0] i2_count;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int rx_cnt    = 0;
   logic [7:0] exp_q[$];

   always #5 clock = ~clock;

   pipeline_elastic #(.NUMS(10), .BITS(8), .SKID(1), .MODE(0)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
      .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
      .count(count)
   );

   pipeline_elastic #(.NUMS(10), .BITS(8), .SKID(0), .MODE(1)) dut_inc (
      .clock(clock), .reset_n(reset_n), .flush(i2_flush),
      .in_value(i2_in_value), .in_valid(i2_in_valid), .in_ready(i2_in_ready),
      .out_value(i2_out_value), .out_valid(i2_out_valid), .out_ready(i2_out_ready),
      .count(i2_count)
   );

   // Scoreboard: push on accepted input, pop and compare on emitted output.
   always @(negedge clock) begin
      if (!reset_n || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            rx_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected: got %0h required no output", out_value);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (out_value !== e) $display("FAIL sb_data: got %0h required %0h", out_value, e);
               else pass_cnt++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_value);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      @(negedge clock);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_value !== 8'h00) $display("FAIL rst_out_value: got %0h required 0", out_value); else pass_cnt++;
      total_cnt++; if (count !== 4'd0) $display("FAIL rst_count: got %0d required 0", count); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else pass_cnt++;
      total_cnt++; if (i2_in_ready !== 1'b1 || i2_count !== 4'd0)
         $display("FAIL rst_nskid: got ready %b count %0d required 1 0", i2_in_ready, i2_count); else pass_cnt++;
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_stream;
      int sent = 0;
      int first_out = -1;
      int rx0;
      rx0 = rx_cnt;
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         in_valid = (sent < 16);
         in_value = 8'(sent);
         @(negedge clock);
         if (out_valid && first_out < 0) first_out = c;
         if (c == 14) begin
            total_cnt++; if (count !== 4'd10) $display("FAIL stream_count: got %0d required 10", count); else pass_cnt++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      total_cnt++; if (first_out != 10) $display("FAIL stream_latency: got %0d required 10", first_out); else pass_cnt++;
      total_cnt++; if (rx_cnt - rx0 != 16) $display("FAIL stream_rx: got %0d required 16", rx_cnt - rx0); else pass_cnt++;
   endtask

   task automatic test_inc;
      logic [7:0] vin  [3] = '{8'hF8, 8'h05, 8'hFF};
      logic [7:0] vexp [3] = '{8'h02, 8'h0F, 8'h09};
      i2_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int lat = 0;
         i2_in_valid = 1'b1;
         i2_in_value = vin[i];
         @(negedge clock);
         total_cnt++; if (i2_in_ready !== 1'b1) $display("FAIL inc_in_ready: got %b required 1", i2_in_ready); else pass_cnt++;
         @(posedge clock); #1;
         i2_in_valid = 1'b0;
         lat = 1;
         while (!i2_out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
         end
         total_cnt++; if (lat != 10) $display("FAIL inc_latency: got %0d required 10", lat); else pass_cnt++;
         total_cnt++; if (i2_out_value !== vexp[i]) $display("FAIL inc_value: got %0h required %0h", i2_out_value, vexp[i]); else pass_cnt++;
         @(posedge clock); #1;
      end
   endtask

   task automatic test_skid;
      int sent = 0;
      int rx0;
      rx0 = rx_cnt;
      for (int c = 0; c < 45; c++) begin
         out_ready = (c != 12);
         in_valid  = (c < 20);
         in_value  = 8'(100 + sent);
         @(negedge clock);
         if (c == 12) begin
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL skid_capture_ready: got %b required 1", in_ready); else pass_cnt++;
         end
         if (c == 13) begin
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL skid_full_ready: got %b required 0", in_ready); else pass_cnt++;
            total_cnt++; if (count !== 4'd11) $display("FAIL skid_count: got %0d required 11", count); else pass_cnt++;
         end
         if (c == 14) begin
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL skid_drain_ready: got %b required 1", in_ready); else pass_cnt++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      total_cnt++; if (rx_cnt - rx0 != sent) $display("FAIL skid_rx: got %0d required %0d", rx_cnt - rx0, sent); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL skid_left: got %0d required 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_random;
      int sent = 0;
      int cyc = 0;
      int dep_err = 0;
      int rx0;
      logic r0;
      rx0 = rx_cnt;
      while (sent < 1000 && cyc < 8000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_value  = 8'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         #1;
         r0 = in_ready;
         out_ready = ~out_ready;
         #1;
         if (in_ready !== r0) dep_err++;
         out_ready = ~out_ready;
         @(negedge clock);
         if (in_valid && in_ready) sent++;
         @(posedge clock); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (30) @(posedge clock);
      #1;
      total_cnt++; if (sent != 1000) $display("FAIL rand_sent: got %0d required 1000", sent); else pass_cnt++;
      total_cnt++; if (rx_cnt - rx0 != 1000) $display("FAIL rand_rx: got %0d required 1000", rx_cnt - rx0); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL rand_left: got %0d required 0", exp_q.size()); else pass_cnt++;
      total_cnt++; if (dep_err != 0) $display("FAIL rand_ready_path: got %0d required 0", dep_err); else pass_cnt++;
   endtask

   task automatic test_flush;
      int seen = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         in_valid = 1'b1;
         in_value = 8'(c + 8'h30);
         @(posedge clock); #1;
      end
      flush    = 1'b1;
      in_value = 8'hEE;
      @(negedge clock);
      total_cnt++; if (count !== 4'd7) $display("FAIL flush_pre_count: got %0d required 7", count); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b required 0", in_ready); else pass_cnt++;
      @(posedge clock); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b required 0", out_valid); else pass_cnt++;
      total_cnt++; if (count !== 4'd0) $display("FAIL flush_count: got %0d required 0", count); else pass_cnt++;
      @(posedge clock); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clock);
         if (out_valid) seen++;
         @(posedge clock); #1;
      end
      total_cnt++; if (seen != 0) $display("FAIL flush_leak: got %0d required 0", seen); else pass_cnt++;
   endtask

   task automatic test_async_reset;
      int rx1;
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1;
         in_value = 8'(200 + c);
         @(posedge clock); #1;
      end
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b required 0", out_valid); else pass_cnt++;
      total_cnt++; if (count !== 4'd0) $display("FAIL arst_count: got %0d required 0", count); else pass_cnt++;
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      rx1 = rx_cnt;
      for (int c = 0; c < 25; c++) begin
         in_valid = (c < 5);
         in_value = 8'(50 + c);
         @(posedge clock); #1;
      end
      total_cnt++; if (rx_cnt - rx1 != 5) $display("FAIL arst_resume_rx: got %0d required 5", rx_cnt - rx1); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL arst_left: got %0d required 0", exp_q.size()); else pass_cnt++;
   endtask

   initial begin
      reset_n      = 1'b0;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_value     = 8'h00;
      out_ready    = 1'b0;
      i2_flush     = 1'b0;
      i2_in_valid  = 1'b0;
      i2_in_value  = 8'h00;
      i2_out_ready = 1'b0;
      test_reset;
      test_stream;
      test_inc;
      test_skid;
      test_random;
      test_flush;
      test_async_reset;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
